// File: rtl/qclk_pulse_trig.sv
// Quantum clock (qclk) and pulse-trigger timing.
// Keeps the program qclk, stages pulse commands and releases each one on its
// requested qclk tick. A request whose time has already passed fires at once
// so the control FSM never waits forever, and it sets a sticky late flag.
module qclk_pulse_trig #(
  parameter int unsigned QCLK_WIDTH       = 32,
  parameter int unsigned PULSE_DATA_WIDTH = 64,
  parameter int unsigned FIRE_CNT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sync_reset,
  input  logic                        qclk_load_en,
  input  logic [QCLK_WIDTH-1:0]       qclk_load_val,
  output logic [QCLK_WIDTH-1:0]       qclk_out,
  input  logic                        write_pulse_en,
  input  logic [QCLK_WIDTH-1:0]       pulse_time_in,
  input  logic [PULSE_DATA_WIDTH-1:0] pulse_data_in,
  input  logic                        c_strobe_enable,
  output logic                        cstrobe_out,
  output logic                        pulse_valid_out,
  output logic [PULSE_DATA_WIDTH-1:0] pulse_data_out,
  output logic                        late_err,
  input  logic                        late_clr,
  output logic [FIRE_CNT_WIDTH-1:0]   fire_count
);

  localparam logic [QCLK_WIDTH-1:0]     QclkOne = {{(QCLK_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [FIRE_CNT_WIDTH-1:0] CntOne  = {{(FIRE_CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StFired
  } state_e;

  state_e                      state_q;
  logic [QCLK_WIDTH-1:0]       qclk_q;
  logic [QCLK_WIDTH-1:0]       time_q;
  logic [PULSE_DATA_WIDTH-1:0] data_q;
  logic                        pulse_valid_q;
  logic [PULSE_DATA_WIDTH-1:0] pulse_data_q;
  logic                        late_err_q;
  logic [FIRE_CNT_WIDTH-1:0]   fire_count_q;

  logic [QCLK_WIDTH-1:0]       eff_time;
  logic [PULSE_DATA_WIDTH-1:0] eff_data;
  logic [QCLK_WIDTH-1:0]       diff;
  logic                        hit;
  logic                        late;
  logic                        fire;

  // Compare against the current request: a write this cycle bypasses staging.
  always_comb begin
    eff_time = write_pulse_en ? pulse_time_in : time_q;
    eff_data = write_pulse_en ? pulse_data_in : data_q;
    // Modular difference: MSB set means the target is still ahead (wrap-safe).
    diff     = qclk_q - eff_time;
    hit      = (diff == '0);
    late     = (diff != '0) && !diff[QCLK_WIDTH-1];
    fire     = c_strobe_enable && (state_q != StFired) && (hit || late) && !reset;
  end

  // qclk: sync clear beats load beats increment; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qclk_q <= '0;
    end else if (sync_reset) begin
      qclk_q <= '0;
    end else if (qclk_load_en) begin
      qclk_q <= qclk_load_val;
    end else begin
      qclk_q <= qclk_q + QclkOne;
    end
  end

  // Pulse staging registers; kept across an FSM abort so a retry can reuse them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_q <= '0;
      data_q <= '0;
    end else if (write_pulse_en) begin
      time_q <= pulse_time_in;
      data_q <= pulse_data_in;
    end
  end

  // Trigger FSM with registered issue outputs; FIRED blocks re-fire until enable drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pulse_valid_q <= 1'b0;
      pulse_data_q  <= '0;
      late_err_q    <= 1'b0;
      fire_count_q  <= '0;
    end else begin
      pulse_valid_q <= fire;
      if (fire) begin
        pulse_data_q <= eff_data;
        fire_count_q <= fire_count_q + CntOne;
      end
      // A late fire sets the flag even if a clear is requested in the same cycle.
      if (fire && !hit) begin
        late_err_q <= 1'b1;
      end else if (late_clr) begin
        late_err_q <= 1'b0;
      end
      unique case (state_q)
        StIdle, StArmed: begin
          if (fire) begin
            state_q <= StFired;
          end else if (c_strobe_enable) begin
            state_q <= StArmed;
          end else begin
            state_q <= StIdle;
          end
        end
        StFired: begin
          if (!c_strobe_enable) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign qclk_out        = qclk_q;
  assign cstrobe_out     = fire;
  assign pulse_valid_out = pulse_valid_q;
  assign pulse_data_out  = pulse_data_q;
  assign late_err        = late_err_q;
  assign fire_count      = fire_count_q;

endmodule

// File: tb/tb_qclk_pulse_trig.sv
// Directed bench for qclk_pulse_trig: inputs change at the falling edge, outputs
// are checked 1 time unit later, well clear of the rising (active) edge.
module tb_qclk_pulse_trig;

  logic        clk;
  logic        reset;
  logic        sync_reset;
  logic        qclk_load_en;
  logic [31:0] qclk_load_val;
  logic [31:0] qclk_out;
  logic        write_pulse_en;
  logic [31:0] pulse_time_in;
  logic [63:0] pulse_data_in;
  logic        c_strobe_enable;
  logic        cstrobe_out;
  logic        pulse_valid_out;
  logic [63:0] pulse_data_out;
  logic        late_err;
  logic        late_clr;
  logic [15:0] fire_count;

  int checks = 0;
  int errors = 0;

  qclk_pulse_trig #(
    .QCLK_WIDTH      (32),
    .PULSE_DATA_WIDTH(64),
    .FIRE_CNT_WIDTH  (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sync_reset     (sync_reset),
    .qclk_load_en   (qclk_load_en),
    .qclk_load_val  (qclk_load_val),
    .qclk_out       (qclk_out),
    .write_pulse_en (write_pulse_en),
    .pulse_time_in  (pulse_time_in),
    .pulse_data_in  (pulse_data_in),
    .c_strobe_enable(c_strobe_enable),
    .cstrobe_out    (cstrobe_out),
    .pulse_valid_out(pulse_valid_out),
    .pulse_data_out (pulse_data_out),
    .late_err       (late_err),
    .late_clr       (late_clr),
    .fire_count     (fire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    sync_reset      = 1'b0;
    qclk_load_en    = 1'b0;
    qclk_load_val   = '0;
    write_pulse_en  = 1'b0;
    pulse_time_in   = '0;
    pulse_data_in   = '0;
    c_strobe_enable = 1'b0;
    late_clr        = 1'b0;

    // Reset state
    repeat (3) tick();
    settle();
    chk("rst_qclk", 64'(qclk_out), 64'd0);
    chk("rst_cstrobe", 64'(cstrobe_out), 64'd0);
    chk("rst_valid", 64'(pulse_valid_out), 64'd0);
    chk("rst_data", pulse_data_out, 64'd0);
    chk("rst_late", 64'(late_err), 64'd0);
    chk("rst_count", 64'(fire_count), 64'd0);

    // Release: cycle 1 shows qclk=0, cycle 10 shows qclk=9
    tick();
    reset = 1'b0;
    settle();
    chk("rel_qclk0", 64'(qclk_out), 64'd0);
    repeat (9) tick();
    settle();
    chk("rel_qclk9", 64'(qclk_out), 64'd9);
    chk("rel_cstrobe", 64'(cstrobe_out), 64'd0);
    chk("rel_count", 64'(fire_count), 64'd0);

    // On-time hit: request at qclk=5 for time 20
    tick();
    qclk_load_en  = 1'b1;
    qclk_load_val = 32'd5;
    tick();
    qclk_load_en    = 1'b0;
    write_pulse_en  = 1'b1;
    pulse_time_in   = 32'd20;
    pulse_data_in   = 64'hA5;
    c_strobe_enable = 1'b1;
    settle();
    chk("hit_qclk5", 64'(qclk_out), 64'd5);
    chk("hit_wait5", 64'(cstrobe_out), 64'd0);
    tick();
    write_pulse_en = 1'b0;
    pulse_data_in  = 64'hDEAD;
    for (int q = 6; q < 20; q++) begin
      settle();
      chk("hit_wait", 64'(cstrobe_out), 64'd0);
      tick();
    end
    settle();
    chk("hit_qclk20", 64'(qclk_out), 64'd20);
    chk("hit_strobe", 64'(cstrobe_out), 64'd1);
    chk("hit_valid_early", 64'(pulse_valid_out), 64'd0);
    tick();
    settle();
    chk("hit_valid", 64'(pulse_valid_out), 64'd1);
    chk("hit_data", pulse_data_out, 64'hA5);
    chk("hit_count", 64'(fire_count), 64'd1);
    chk("hit_late", 64'(late_err), 64'd0);
    chk("hit_no_refire", 64'(cstrobe_out), 64'd0);

    // Enable held after the hit: no second strobe or issue
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk("hold_strobe", 64'(cstrobe_out), 64'd0);
      chk("hold_valid", 64'(pulse_valid_out), 64'd0);
    end
    chk("hold_qclk24", 64'(qclk_out), 64'd24);
    chk("hold_count", 64'(fire_count), 64'd1);

    // Drop enable, then re-arm with time = qclk + 3
    tick();
    c_strobe_enable = 1'b0;
    tick();
    write_pulse_en  = 1'b1;
    pulse_time_in   = 32'd29;
    pulse_data_in   = 64'h5A5A;
    c_strobe_enable = 1'b1;
    settle();
    chk("rearm_qclk26", 64'(qclk_out), 64'd26);
    chk("rearm_wait", 64'(cstrobe_out), 64'd0);
    tick();
    write_pulse_en = 1'b0;
    settle();
    chk("rearm_wait27", 64'(cstrobe_out), 64'd0);
    tick();
    settle();
    chk("rearm_wait28", 64'(cstrobe_out), 64'd0);
    tick();
    settle();
    chk("rearm_strobe29", 64'(cstrobe_out), 64'd1);
    tick();
    c_strobe_enable = 1'b0;
    settle();
    chk("rearm_valid", 64'(pulse_valid_out), 64'd1);
    chk("rearm_data", pulse_data_out, 64'h5A5A);
    chk("rearm_count", 64'(fire_count), 64'd2);
    tick();
    settle();
    chk("rearm_valid_once", 64'(pulse_valid_out), 64'd0);
    chk("rearm_data_held", pulse_data_out, 64'h5A5A);

    // Late request: qclk=50, time=40 fires at once and sets late_err
    qclk_load_en  = 1'b1;
    qclk_load_val = 32'd50;
    tick();
    qclk_load_en    = 1'b0;
    write_pulse_en  = 1'b1;
    pulse_time_in   = 32'd40;
    pulse_data_in   = 64'h77;
    c_strobe_enable = 1'b1;
    settle();
    chk("late_qclk50", 64'(qclk_out), 64'd50);
    chk("late_strobe", 64'(cstrobe_out), 64'd1);
    chk("late_flag_pre", 64'(late_err), 64'd0);
    tick();
    write_pulse_en  = 1'b0;
    c_strobe_enable = 1'b0;
    late_clr        = 1'b1;
    settle();
    chk("late_flag", 64'(late_err), 64'd1);
    chk("late_valid", 64'(pulse_valid_out), 64'd1);
    chk("late_data", pulse_data_out, 64'h77);
    chk("late_count", 64'(fire_count), 64'd3);
    tick();
    late_clr = 1'b0;
    settle();
    chk("late_cleared", 64'(late_err), 64'd0);

    // Wrap: load 0xFFFF_FFFE, request time 1 -> fires three ticks later, not late
    qclk_load_en  = 1'b1;
    qclk_load_val = 32'hFFFF_FFFE;
    tick();
    qclk_load_en    = 1'b0;
    write_pulse_en  = 1'b1;
    pulse_time_in   = 32'd1;
    pulse_data_in   = 64'h1234;
    c_strobe_enable = 1'b1;
    settle();
    chk("wrap_qclk", 64'(qclk_out), 64'hFFFF_FFFE);
    chk("wrap_wait0", 64'(cstrobe_out), 64'd0);
    tick();
    write_pulse_en = 1'b0;
    settle();
    chk("wrap_wait1", 64'(cstrobe_out), 64'd0);
    tick();
    settle();
    chk("wrap_qclk0", 64'(qclk_out), 64'd0);
    chk("wrap_wait2", 64'(cstrobe_out), 64'd0);
    tick();
    settle();
    chk("wrap_strobe", 64'(cstrobe_out), 64'd1);
    tick();
    c_strobe_enable = 1'b0;
    settle();
    chk("wrap_valid", 64'(pulse_valid_out), 64'd1);
    chk("wrap_data", pulse_data_out, 64'h1234);
    chk("wrap_late", 64'(late_err), 64'd0);
    chk("wrap_count", 64'(fire_count), 64'd4);

    // sync_reset wins over qclk_load_en
    sync_reset    = 1'b1;
    qclk_load_en  = 1'b1;
    qclk_load_val = 32'h100;
    tick();
    sync_reset   = 1'b0;
    qclk_load_en = 1'b0;
    settle();
    chk("sync_qclk", 64'(qclk_out), 64'd0);

    // Async reset while ARMED: back to idle, no issue afterwards
    write_pulse_en  = 1'b1;
    pulse_time_in   = 32'd10;
    pulse_data_in   = 64'h99;
    c_strobe_enable = 1'b1;
    tick();
    write_pulse_en = 1'b0;
    settle();
    chk("armed_wait", 64'(cstrobe_out), 64'd0);
    reset = 1'b1;
    c_strobe_enable = 1'b0;
    settle();
    chk("arst_qclk", 64'(qclk_out), 64'd0);
    chk("arst_strobe", 64'(cstrobe_out), 64'd0);
    chk("arst_count", 64'(fire_count), 64'd0);
    chk("arst_data", pulse_data_out, 64'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      settle();
      chk("arst_no_valid", 64'(pulse_valid_out), 64'd0);
    end
    chk("arst_count_end", 64'(fire_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
